fetch_unit: RTL and testbench
=============================

Name: fetch_unit

Overview:
- Instruction-fetch front end that sits between the synchronous instruction ROM (imem) and the processor datapath.
- Owns the program counter and drives the 12-bit imem address each cycle.
- Captures the ROM's one-cycle-latency output and hands instructions downstream with a valid/stall handshake.
- A one-entry skid buffer ensures no fetched word is lost or duplicated under stall; a branch/jump redirect flushes all in-flight state.

Parameters:
- PC_WIDTH, 12, width of PC and imem address; PC arithmetic wraps modulo 2^PC_WIDTH.
- INSN_WIDTH, 32, instruction word width.
- RESET_PC, 0, PC value loaded on reset.

Ports:
- clock  in  1  processor clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-high; clears all state immediately.
- stall  in  1  downstream cannot accept insn_out this cycle.
- redirect_valid  in  1  taken branch/jump; fetch resumes at redirect_target.
- redirect_target  in  PC_WIDTH  new fetch address.
- address_imem  out  PC_WIDTH  imem address; equals the pc register (combinational from register).
- q_imem  in  INSN_WIDTH  imem data; valid one cycle after its address was presented.
- insn_out  out  INSN_WIDTH  instruction presented downstream.
- insn_valid  out  1  insn_out/pc_out are meaningful.
- pc_out  out  PC_WIDTH  address of insn_out.
- pc_plus1_out  out  PC_WIDTH  pc_out+1 mod 2^PC_WIDTH, combinational, for jal/link.

Behaviour:
- State registers:
  - pc.
  - req_valid, req_pc: a request is in flight; q_imem this cycle belongs to req_pc.
  - out_valid, out_insn, out_pc.
  - skid_valid, skid_insn, skid_pc.
- Reset (async, any time including mid-operation):
  - pc=RESET_PC.
  - req_valid, out_valid, skid_valid = 0.
  - out_insn, out_pc, skid_* = 0.
  - Hence insn_valid=0, insn_out=0, pc_out=0, address_imem=RESET_PC.
- issue = ~(stall & out_valid & (skid_valid | req_valid)).
- Rising edge, redirect_valid=1 (priority over everything except reset):
  - pc <= redirect_target.
  - req_valid, out_valid, skid_valid <= 0.
  - The returning q_imem is discarded.
  - First redirected instruction appears valid 2 edges later, assuming no stall.
- Rising edge, redirect_valid=0, output stage:
  - out_free = ~out_valid | ~stall.
  - If out_free and skid_valid: out <= skid; if req_valid, skid <= {q_imem, req_pc}, else skid_valid <= 0.
  - If out_free and ~skid_valid: if req_valid, out <= {q_imem, req_pc}, else out_valid <= 0.
  - If ~out_free: out holds; if req_valid, skid <= {q_imem, req_pc} (skid is guaranteed empty here).
- Rising edge, redirect_valid=0, fetch stage:
  - If issue: req_valid <= 1, req_pc <= pc, pc <= pc+1 (wraps 4095->0 at default width).
  - Else: req_valid <= 0 and pc holds.
- Latency and throughput:
  - Address to insn_valid is 2 edges.
  - Steady-state throughput is one instruction per cycle with no bubbles when stall=0.
- Invariants (assert in bench):
  - skid_valid implies ~req_valid or out_free.
  - No instruction is dropped or duplicated.
  - pc_out sequence is strictly consecutive between redirects.
- While stall=1 and insn_valid=1, insn_out and pc_out are held stable.
- Stall with insn_valid=0 has no effect on the output stage.
- Redirect and stall asserted in the same cycle: redirect wins; the output is flushed.

Test Plan:
- Reset release, imem[i]=0x1000_0000+i, stall=0 -> insn_valid rises on 2nd edge with pc_out=0, insn_out=0x1000_0000; then pc_out 1,2,3 on consecutive cycles with no bubbles.
- Stall held 3 cycles while pc_out=5 -> insn_out/pc_out stay 5; address_imem stops advancing after skid fills; after release, pc_out sequence is 6,7,8 with no gap or duplicate.
- redirect_valid with target 0x040 while pc_out=10 and a request in flight -> next edge insn_valid=0; pc_out=0x040 valid 2 edges later; instructions 11 and 12 never appear.
- Redirect to 0xFFE, free-running -> pc_out 0xFFE, 0xFFF, 0x000; pc_plus1_out 0xFFF, 0x000, 0x001.
- Reset asserted asynchronously mid-stall with skid full -> outputs clear without a clock edge; after release, fetch restarts at RESET_PC=0.
- Redirect and stall in the same cycle with skid full -> flushed; first post-redirect instruction delivered correctly once stall drops.

Source files
------------

// File: rtl/fetch_unit_if.sv
// fetch_unit_if: bundles the imem port, the redirect request and the
// downstream instruction handshake of the fetch unit.
//   master : the fetch unit (drives imem address and downstream instruction)
//   slave  : the surrounding core/ROM (drives stall, redirect, imem data)
interface fetch_unit_if #(
  parameter int unsigned PC_WIDTH   = 12,
  parameter int unsigned INSN_WIDTH = 32
);
  // downstream / control inputs to the fetch unit
  logic                  stall;
  logic                  redirect_valid;
  logic [PC_WIDTH-1:0]   redirect_target;
  // imem side
  logic [PC_WIDTH-1:0]   address_imem;
  logic [INSN_WIDTH-1:0] q_imem;
  // downstream instruction
  logic [INSN_WIDTH-1:0] insn_out;
  logic                  insn_valid;
  logic [PC_WIDTH-1:0]   pc_out;
  logic [PC_WIDTH-1:0]   pc_plus1_out;

  modport master (
    input  stall, redirect_valid, redirect_target, q_imem,
    output address_imem, insn_out, insn_valid, pc_out, pc_plus1_out
  );

  modport slave (
    output stall, redirect_valid, redirect_target, q_imem,
    input  address_imem, insn_out, insn_valid, pc_out, pc_plus1_out
  );
endinterface

// File: rtl/fetch_unit.sv
// fetch_unit: instruction-fetch front end between a synchronous
// (one-cycle latency) instruction ROM and the datapath. Owns the PC,
// tracks the in-flight ROM request, and delivers instructions through an
// output register backed by a one-entry skid buffer so stalls never drop
// or duplicate a fetched word. A redirect flushes all in-flight state.
// Ports:
//   clock  - rising-edge clock
//   reset  - asynchronous, active-high reset
//   bus    - fetch_unit_if.master: stall/redirect in, imem address/data,
//            insn_out/insn_valid/pc_out/pc_plus1_out downstream
module fetch_unit #(
  parameter int unsigned PC_WIDTH   = 12,
  parameter int unsigned INSN_WIDTH = 32,
  parameter int unsigned RESET_PC   = 0
) (
  input  logic          clock,
  input  logic          reset,
  fetch_unit_if.master  bus
);

  // instruction word paired with the address it was fetched from
  typedef struct packed {
    logic [INSN_WIDTH-1:0] insn;
    logic [PC_WIDTH-1:0]   pc;
  } entry_t;

  localparam logic [PC_WIDTH-1:0] RESET_PC_W = PC_WIDTH'(RESET_PC);

  logic [PC_WIDTH-1:0] pc_q, pc_d;
  logic                req_valid_q, req_valid_d;
  logic [PC_WIDTH-1:0] req_pc_q, req_pc_d;
  logic                out_valid_q, out_valid_d;
  entry_t              out_q, out_d;
  logic                skid_valid_q, skid_valid_d;
  entry_t              skid_q, skid_d;

  logic   issue_c;
  logic   out_free_c;
  entry_t ret_c;

  // ROM word returning this cycle, tagged with the address that requested it
  assign ret_c = '{insn: bus.q_imem, pc: req_pc_q};

  // stop fetching only when a stalled output could not absorb another word
  assign issue_c    = ~(bus.stall & out_valid_q & (skid_valid_q | req_valid_q));
  assign out_free_c = ~out_valid_q | ~bus.stall;

  // next-state logic for fetch, output and skid stages
  always_comb begin
    pc_d         = pc_q;
    req_valid_d  = req_valid_q;
    req_pc_d     = req_pc_q;
    out_valid_d  = out_valid_q;
    out_d        = out_q;
    skid_valid_d = skid_valid_q;
    skid_d       = skid_q;

    if (bus.redirect_valid) begin
      // flush everything; the word returning this cycle is discarded
      pc_d         = bus.redirect_target;
      req_valid_d  = 1'b0;
      out_valid_d  = 1'b0;
      skid_valid_d = 1'b0;
    end else begin
      // output stage
      if (out_free_c) begin
        if (skid_valid_q) begin
          out_valid_d = 1'b1;
          out_d       = skid_q;
          if (req_valid_q) begin
            skid_d = ret_c;
          end else begin
            skid_valid_d = 1'b0;
          end
        end else if (req_valid_q) begin
          out_valid_d = 1'b1;
          out_d       = ret_c;
        end else begin
          out_valid_d = 1'b0;
        end
      end else if (req_valid_q) begin
        // output held; skid is necessarily empty because issue was blocked
        skid_valid_d = 1'b1;
        skid_d       = ret_c;
      end

      // fetch stage
      if (issue_c) begin
        req_valid_d = 1'b1;
        req_pc_d    = pc_q;
        pc_d        = pc_q + PC_WIDTH'(1);
      end else begin
        req_valid_d = 1'b0;
      end
    end
  end

  // state registers
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pc_q         <= RESET_PC_W;
      req_valid_q  <= 1'b0;
      req_pc_q     <= '0;
      out_valid_q  <= 1'b0;
      out_q        <= '0;
      skid_valid_q <= 1'b0;
      skid_q       <= '0;
    end else begin
      pc_q         <= pc_d;
      req_valid_q  <= req_valid_d;
      req_pc_q     <= req_pc_d;
      out_valid_q  <= out_valid_d;
      out_q        <= out_d;
      skid_valid_q <= skid_valid_d;
      skid_q       <= skid_d;
    end
  end

  assign bus.address_imem = pc_q;
  assign bus.insn_out     = out_q.insn;
  assign bus.insn_valid   = out_valid_q;
  assign bus.pc_out       = out_q.pc;
  // link address for jal; wraps with the PC
  assign bus.pc_plus1_out = out_q.pc + PC_WIDTH'(1);

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: bench for fetch_unit with a synchronous ROM model
// (word = 0x1000_0000 + address), a scoreboard of expected delivery
// addresses refilled on reset/redirect, and directed latency/boundary checks.
module tb_fetch_unit;

  localparam int unsigned PW = 12;
  localparam int unsigned IW = 32;

  logic clock;
  logic reset;
  int   n_checks = 0;
  int   n_errors = 0;

  logic [PW-1:0] exp_q[$];
  logic [PW-1:0] next_push;

  fetch_unit_if #(.PC_WIDTH(PW), .INSN_WIDTH(IW)) bus ();

  fetch_unit #(.PC_WIDTH(PW), .INSN_WIDTH(IW), .RESET_PC(0)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic logic [31:0] rom(input logic [PW-1:0] a);
    return 32'h1000_0000 + 32'(a);
  endfunction

  // synchronous ROM with one-cycle latency
  always @(posedge clock) bus.q_imem <= rom(bus.address_imem);

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic refill(input logic [PW-1:0] start);
    exp_q.delete();
    next_push = start;
    for (int i = 0; i < 16; i++) begin
      exp_q.push_back(next_push);
      next_push = next_push + PW'(1);
    end
  endtask

  // scoreboard monitor, sampled on the falling edge
  always @(negedge clock) begin
    logic [PW-1:0] e;
    logic [PW-1:0] e1;
    logic          out_free;
    if (reset) begin
      refill(PW'(0));
    end else begin
      if (bus.insn_valid) begin
        check("sb_nonempty", 32'(exp_q.size() > 0), 32'd1);
        if (exp_q.size() > 0) begin
          e  = exp_q[0];
          e1 = e + PW'(1);
          check("sb_pc", 32'(bus.pc_out), 32'(e));
          check("sb_insn", bus.insn_out, rom(e));
          check("sb_pc1", 32'(bus.pc_plus1_out), 32'(e1));
        end
      end
      out_free = !dut.out_valid_q || !bus.stall;
      check("inv_skid", 32'(!dut.skid_valid_q || !dut.req_valid_q || out_free), 32'd1);
      if (bus.redirect_valid) begin
        refill(bus.redirect_target);
      end else if (bus.insn_valid && !bus.stall && exp_q.size() > 0) begin
        void'(exp_q.pop_front());
        exp_q.push_back(next_push);
        next_push = next_push + PW'(1);
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic expect_out(input string tag, input logic v, input logic [PW-1:0] pc);
    logic [PW-1:0] pc1;
    pc1 = pc + PW'(1);
    check({tag, "_valid"}, 32'(bus.insn_valid), 32'(v));
    if (v) begin
      check({tag, "_pc"}, 32'(bus.pc_out), 32'(pc));
      check({tag, "_insn"}, bus.insn_out, rom(pc));
      check({tag, "_pc1"}, 32'(bus.pc_plus1_out), 32'(pc1));
    end
  endtask

  task automatic run_until_pc(input logic [PW-1:0] target, input int max_cycles);
    int n;
    n = 0;
    while (!(bus.insn_valid && bus.pc_out == target) && n < max_cycles) begin
      tick();
      n++;
    end
    check("reach_pc", 32'(bus.pc_out), 32'(target));
  endtask

  task automatic redirect_to(input logic [PW-1:0] t);
    bus.redirect_valid  = 1'b1;
    bus.redirect_target = t;
    tick();
    bus.redirect_valid  = 1'b0;
  endtask

  initial begin
    reset               = 1'b1;
    bus.stall           = 1'b0;
    bus.redirect_valid  = 1'b0;
    bus.redirect_target = '0;
    #1;
    check("rst_valid", 32'(bus.insn_valid), 32'd0);
    check("rst_insn", bus.insn_out, 32'd0);
    check("rst_pc", 32'(bus.pc_out), 32'd0);
    check("rst_addr", 32'(bus.address_imem), 32'd0);
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;

    // startup latency and back-to-back delivery
    tick();
    expect_out("start_e1", 1'b0, 12'h000);
    tick();
    expect_out("start_e2", 1'b1, 12'h000);
    for (int i = 1; i <= 3; i++) begin
      tick();
      expect_out("stream", 1'b1, PW'(i));
    end

    // stall hold with skid fill
    run_until_pc(12'h005, 20);
    bus.stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      expect_out("stall_hold", 1'b1, 12'h005);
      check("stall_addr", 32'(bus.address_imem), 32'h007);
    end
    bus.stall = 1'b0;
    for (int i = 6; i <= 8; i++) begin
      tick();
      expect_out("stall_rel", 1'b1, PW'(i));
    end

    // redirect with request in flight
    run_until_pc(12'h00A, 20);
    check("redir_inflight", 32'(dut.req_valid_q), 32'd1);
    redirect_to(12'h040);
    expect_out("redir_e1", 1'b0, 12'h000);
    tick();
    expect_out("redir_e2", 1'b0, 12'h000);
    tick();
    expect_out("redir_e3", 1'b1, 12'h040);

    // wrap at top of address space
    redirect_to(12'hFFE);
    tick();
    tick();
    expect_out("wrap0", 1'b1, 12'hFFE);
    tick();
    expect_out("wrap1", 1'b1, 12'hFFF);
    tick();
    expect_out("wrap2", 1'b1, 12'h000);

    // async reset mid-stall with skid full
    repeat (3) tick();
    bus.stall = 1'b1;
    tick();
    tick();
    check("rst_skid_full", 32'(dut.skid_valid_q), 32'd1);
    #2 reset = 1'b1;
    #1;
    check("arst_valid", 32'(bus.insn_valid), 32'd0);
    check("arst_insn", bus.insn_out, 32'd0);
    check("arst_pc", 32'(bus.pc_out), 32'd0);
    check("arst_addr", 32'(bus.address_imem), 32'd0);
    @(posedge clock);
    #1;
    reset     = 1'b0;
    bus.stall = 1'b0;
    tick();
    expect_out("rst2_e1", 1'b0, 12'h000);
    tick();
    expect_out("rst2_e2", 1'b1, 12'h000);
    tick();
    expect_out("rst2_e3", 1'b1, 12'h001);

    // redirect and stall together with skid full
    repeat (2) tick();
    bus.stall = 1'b1;
    tick();
    tick();
    check("rs_skid_full", 32'(dut.skid_valid_q), 32'd1);
    redirect_to(12'h123);
    expect_out("rs_flush", 1'b0, 12'h000);
    tick();
    expect_out("rs_e1", 1'b0, 12'h000);
    tick();
    expect_out("rs_e2", 1'b1, 12'h123);
    tick();
    expect_out("rs_e3", 1'b1, 12'h123);
    bus.stall = 1'b0;
    tick();
    expect_out("rs_rel1", 1'b1, 12'h124);
    tick();
    expect_out("rs_rel2", 1'b1, 12'h125);

    // random stall traffic, scoreboard only
    for (int i = 0; i < 200; i++) begin
      bus.stall = 1'($urandom_range(0, 2) == 0);
      tick();
    end
    bus.stall = 1'b0;
    repeat (4) tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
